// File: rtl/gps_point_feeder.sv
// Feeds buffered lon/lat fixes to the GPS distance calculator one at a time.
// It forwards each pair's distance on a ready/valid stream with a running pair index.
module gps_point_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_lon,
    input  logic [23:0] in_lat,
    output logic        DEN,
    output logic [23:0] LON_IN,
    output logic [23:0] LAT_IN,
    input  logic        Valid,
    input  logic [39:0] D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [39:0] out_d,
    output logic [15:0] out_idx,
    output logic        timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SEND = 3'd1;
    localparam logic [2:0] GAP  = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] HOLD = 3'd4;

    logic [47:0]   fix_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    logic [2:0]    state;
    logic          first_pt;
    logic [15:0]   wait_cnt;
    logic [15:0]   idx_cnt;

    // Full is judged on the registered count, so a same-cycle pop never admits a push.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign pop      = (state == IDLE) && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fix_mem[wr_ptr] <= {in_lon, in_lat};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            first_pt    <= 1'b1;
            wait_cnt    <= '0;
            idx_cnt     <= '0;
            DEN         <= 1'b0;
            LON_IN      <= '0;
            LAT_IN      <= '0;
            out_valid   <= 1'b0;
            out_d       <= '0;
            out_idx     <= '0;
            timeout_err <= 1'b0;
        end else begin
            DEN <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        LON_IN <= fix_mem[rd_ptr][47:24];
                        LAT_IN <= fix_mem[rd_ptr][23:0];
                        DEN    <= 1'b1;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    // A reference point produces no distance, so skip waiting for one.
                    if (first_pt) begin
                        first_pt <= 1'b0;
                        state    <= GAP;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                WAIT: begin
                    if (Valid) begin
                        out_d     <= D;
                        idx_cnt   <= idx_cnt + 16'd1;
                        out_idx   <= idx_cnt + 16'd1;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (wait_cnt == TO_LAST) begin
                        // Give up on this pair and restart the chain from the next fix.
                        timeout_err <= 1'b1;
                        first_pt    <= 1'b1;
                        idx_cnt     <= '0;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gps_point_feeder.sv
// Directed bench for gps_point_feeder with an in-bench calculator model that answers each DEN
// according to a per-point plan.
module tb_gps_point_feeder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_lon = '0;
    logic [23:0] in_lat = '0;
    logic        DEN;
    logic [23:0] LON_IN;
    logic [23:0] LAT_IN;
    logic        Valid = 1'b0;
    logic [39:0] D = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [39:0] out_d;
    logic [15:0] out_idx;
    logic        timeout_err;

    always #5 clk = ~clk;

    gps_point_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_lon(in_lon), .in_lat(in_lat),
        .DEN(DEN), .LON_IN(LON_IN), .LAT_IN(LAT_IN),
        .Valid(Valid), .D(D),
        .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_idx(out_idx),
        .timeout_err(timeout_err)
    );

    // kind: 0 = reference point (no answer), 1 = answered after 5 cycles, 2 = never answered
    typedef struct {logic [23:0] lon; logic [23:0] lat; int kind; logic [39:0] d; logic [15:0] idx;} vec_t;
    typedef struct {int cyc; logic [23:0] lon; logic [23:0] lat;} den_t;
    typedef struct {int cyc; logic [39:0] d; logic [15:0] idx;} res_t;
    typedef struct {logic resp; int delay; logic [39:0] d;} plan_t;

    vec_t  tbl [11];
    den_t  den_q [$];
    res_t  res_q [$];
    plan_t plan [$];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          te_cyc = -1;
    int          pend_cyc = 0;
    logic        pend = 1'b0;
    logic        ov_prev = 1'b0;
    logic [39:0] pend_d = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // Advance one cycle, record DUT events and run the calculator model.
    task automatic tick();
        den_t  e;
        res_t  r;
        plan_t p;
        @(posedge clk);
        #1;
        cyc++;
        if (DEN === 1'b1) begin
            e.cyc = cyc; e.lon = LON_IN; e.lat = LAT_IN;
            den_q.push_back(e);
            if (plan.size() > 0) begin
                p = plan.pop_front();
                if (p.resp) begin
                    pend = 1'b1; pend_cyc = cyc + p.delay; pend_d = p.d;
                end
            end
        end
        if (out_valid === 1'b1 && !ov_prev) begin
            r.cyc = cyc; r.d = out_d; r.idx = out_idx;
            res_q.push_back(r);
        end
        ov_prev = (out_valid === 1'b1);
        if (timeout_err === 1'b1 && te_cyc < 0) te_cyc = cyc;
        Valid = 1'b0;
        if (pend && cyc == pend_cyc) begin
            Valid = 1'b1; D = pend_d; pend = 1'b0;
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; in_valid = 1'b0; Valid = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        den_q.delete(); res_q.delete(); plan.delete();
        pend = 1'b0; te_cyc = -1; ov_prev = 1'b0;
    endtask

    task automatic wait_for(input string nm, input int n_den, input int n_res, input int budget);
        int k = 0;
        while ((den_q.size() < n_den || res_q.size() < n_res) && k < budget) begin
            tick(); k++;
        end
        chk({nm, "_reached"}, (den_q.size() >= n_den && res_q.size() >= n_res), 1);
    endtask

    task automatic stray_pulse(input logic [39:0] d);
        Valid = 1'b1; D = d;
        tick();
    endtask

    task automatic push_rows(input int lo, input int hi);
        plan_t p;
        for (int i = lo; i < hi; i++) begin
            p.resp = (tbl[i].kind == 1); p.delay = 5; p.d = tbl[i].d;
            plan.push_back(p);
        end
        for (int i = lo; i < hi; i++) begin
            in_valid = 1'b1; in_lon = tbl[i].lon; in_lat = tbl[i].lat;
            chk($sformatf("in_ready_push[%0d]", i), in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_rows(input int lo, input int hi, input int db, input int rb);
        int r = rb;
        for (int i = lo; i < hi; i++) begin
            int j;
            j = db + i - lo;
            chk($sformatf("den_present[%0d]", i), (den_q.size() > j), 1);
            if (den_q.size() <= j) continue;
            chk($sformatf("lon[%0d]", i), den_q[j].lon, tbl[i].lon);
            chk($sformatf("lat[%0d]", i), den_q[j].lat, tbl[i].lat);
            if (tbl[i].kind == 0) begin
                if (i + 1 < hi && den_q.size() > j + 1)
                    chk($sformatf("gap_first[%0d]", i), den_q[j+1].cyc - den_q[j].cyc, 3);
            end else if (tbl[i].kind == 1) begin
                chk($sformatf("res_present[%0d]", i), (res_q.size() > r), 1);
                if (res_q.size() > r) begin
                    chk($sformatf("res_d[%0d]", i), res_q[r].d, tbl[i].d);
                    chk($sformatf("res_idx[%0d]", i), res_q[r].idx, tbl[i].idx);
                    chk($sformatf("res_lat[%0d]", i), res_q[r].cyc - den_q[j].cyc, 6);
                    if (i + 1 < hi && den_q.size() > j + 1)
                        chk($sformatf("gap_res[%0d]", i), den_q[j+1].cyc - res_q[r].cyc, 2);
                end
                r++;
            end else begin
                chk($sformatf("timeout_at[%0d]", i), te_cyc - den_q[j].cyc, TIMEOUT + 1);
                if (i + 1 < hi && den_q.size() > j + 1)
                    chk($sformatf("gap_to[%0d]", i), den_q[j+1].cyc - den_q[j].cyc, TIMEOUT + 2);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [39:0] db;
        plan_t       p;

        tbl[0]  = '{24'h123456, 24'h0ABCDE, 0, 40'h0, 16'd0};
        tbl[1]  = '{24'hFFFFFF, 24'h000001, 1, 40'h00_0000_1234, 16'd1};
        tbl[2]  = '{24'h000000, 24'hFFFFFF, 1, 40'hFF_FFFF_FFFF, 16'd2};
        tbl[3]  = '{24'h111111, 24'h222222, 0, 40'h0, 16'd0};
        tbl[4]  = '{24'h333333, 24'h444444, 2, 40'h0, 16'd0};
        tbl[5]  = '{24'h555555, 24'h666666, 0, 40'h0, 16'd0};
        tbl[6]  = '{24'h777777, 24'h888888, 1, 40'h55_AAAA_5555, 16'd1};
        tbl[7]  = '{24'hA00001, 24'hB00001, 1, 40'h00_0000_0101, 16'd2};
        tbl[8]  = '{24'hA00002, 24'hB00002, 1, 40'h00_0000_0202, 16'd3};
        tbl[9]  = '{24'hA00003, 24'hB00003, 1, 40'h00_0000_0303, 16'd4};
        tbl[10] = '{24'hA00004, 24'hB00004, 1, 40'h00_0000_0404, 16'd5};

        // Reset values
        tick(); tick();
        chk("rst_den", DEN, 0);
        chk("rst_lon", LON_IN, 0);
        chk("rst_lat", LAT_IN, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_d", out_d, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_in_ready", in_ready, 1);

        // Three fixes back-to-back, results accepted immediately
        apply_reset();
        out_ready = 1'b1;
        push_rows(0, 3);
        wait_for("three", 3, 2, 200);
        repeat (12) tick();
        check_rows(0, 3, 0, 0);
        chk("three_den_count", den_q.size(), 3);
        chk("three_res_count", res_q.size(), 2);

        // Timeout recovery
        apply_reset();
        out_ready = 1'b1;
        push_rows(3, 7);
        wait_for("timeout", 4, 1, 300);
        repeat (12) tick();
        check_rows(3, 7, 0, 0);
        chk("timeout_sticky", timeout_err, 1);
        chk("timeout_den_count", den_q.size(), 4);

        // Backpressure with FIFO filling behind a held result
        apply_reset();
        out_ready = 1'b0;
        db = 40'h12_3456_789A;
        p = '{1'b0, 5, 40'h0}; plan.push_back(p);
        p = '{1'b1, 5, db};    plan.push_back(p);
        in_valid = 1'b1; in_lon = 24'hC0FFEE; in_lat = 24'h00BEEF; tick();
        in_lon = 24'hC0FFEF; in_lat = 24'h00BEF0; tick();
        in_valid = 1'b0;
        wait_for("bp_first", 2, 1, 100);
        for (int i = 7; i < 11; i++) begin
            p = '{1'b1, 5, tbl[i].d}; plan.push_back(p);
        end
        for (int k = 0; k < 20; k++) begin
            if (k < 6) begin
                in_valid = 1'b1;
                in_lon = (k < 4) ? tbl[7+k].lon : 24'hEE0000 + 24'(k);
                in_lat = (k < 4) ? tbl[7+k].lat : 24'hDD0000 + 24'(k);
                chk($sformatf("bp_in_ready[%0d]", k), in_ready, (k < 4) ? 1 : 0);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk($sformatf("bp_hold[%0d]", k), {out_valid, out_idx, out_d}, {1'b1, 16'd1, db});
        end
        chk("bp_no_den", den_q.size(), 2);
        out_ready = 1'b1;
        tick();
        chk("bp_release_valid", out_valid, 0);
        tick();
        chk("bp_release_den", DEN, 1);
        chk("bp_release_lon", LON_IN, tbl[7].lon);
        wait_for("bp_drain", 6, 5, 200);
        repeat (12) tick();
        check_rows(7, 11, 2, 1);
        chk("bp_den_count", den_q.size(), 6);
        chk("bp_in_ready_end", in_ready, 1);

        // Stray Valid in IDLE and HOLD, then Valid coinciding with the timeout edge
        apply_reset();
        stray_pulse(40'hDEAD);
        tick();
        chk("stray_idle_valid", out_valid, 0);
        chk("stray_idle_idx", out_idx, 0);
        out_ready = 1'b0;
        p = '{1'b0, 5, 40'h0};          plan.push_back(p);
        p = '{1'b1, 5, 40'h00_0000_0AAA}; plan.push_back(p);
        p = '{1'b1, TIMEOUT, 40'h00_0000_0CCC}; plan.push_back(p);
        in_valid = 1'b1; in_lon = 24'h0000A1; in_lat = 24'h0000A2; tick();
        in_lon = 24'h0000B1; in_lat = 24'h0000B2; tick();
        in_valid = 1'b0;
        wait_for("stray_hold", 2, 1, 100);
        stray_pulse(40'h00_0000_0BAD);
        tick();
        chk("stray_hold", {out_valid, out_idx, out_d}, {1'b1, 16'd1, 40'h00_0000_0AAA});
        in_valid = 1'b1; in_lon = 24'h0000C1; in_lat = 24'h0000C2; tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_for("coincide", 3, 2, 100);
        repeat (4) tick();
        if (den_q.size() >= 3 && res_q.size() >= 2) begin
            chk("coincide_d", res_q[1].d, 40'h00_0000_0CCC);
            chk("coincide_idx", res_q[1].idx, 2);
            chk("coincide_cyc", res_q[1].cyc - den_q[2].cyc, TIMEOUT + 1);
        end
        chk("coincide_no_timeout", timeout_err, 0);

        // Reset while waiting with two fixes queued, then a late calculator answer
        apply_reset();
        out_ready = 1'b1;
        p = '{1'b0, 5, 40'h0};          plan.push_back(p);
        p = '{1'b1, 5, 40'h00_0000_0777}; plan.push_back(p);
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_lon = 24'h0F0000 + 24'(k); in_lat = 24'h0E0000 + 24'(k); tick();
        end
        in_valid = 1'b0;
        wait_for("rw_wait", 2, 0, 50);
        tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("rw_den", DEN, 0);
        chk("rw_lon", LON_IN, 0);
        chk("rw_lat", LAT_IN, 0);
        chk("rw_out_valid", out_valid, 0);
        chk("rw_out_d", out_d, 0);
        chk("rw_out_idx", out_idx, 0);
        chk("rw_in_ready", in_ready, 1);
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("rw_late_valid", {out_valid, out_idx, out_d}, {1'b0, 16'd0, 40'd0});
        chk("rw_no_den", den_q.size(), 2);
        chk("rw_late_pending", pend, 0);
        in_valid = 1'b1; in_lon = 24'h0D0D0D; in_lat = 24'h0C0C0C; tick();
        in_valid = 1'b0;
        wait_for("rw_new", 3, 0, 20);
        if (den_q.size() >= 3) chk("rw_new_lon", den_q[2].lon, 24'h0D0D0D);
        repeat (6) tick();
        chk("rw_new_first", {out_valid, timeout_err}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
